// File: rtl/b64_pkg.sv
// Shared definitions for the base64 serial decoder: FSM states, symbol width,
// base64 alphabet ranges and the accumulator sizing helper.
package b64_pkg;

    localparam int SYM_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [6:0] UC_FIRST   = 7'h41;  // 'A'
    localparam logic [6:0] UC_LAST    = 7'h5A;  // 'Z'
    localparam logic [6:0] LC_FIRST   = 7'h61;  // 'a'
    localparam logic [6:0] LC_LAST    = 7'h7A;  // 'z'
    localparam logic [6:0] DG_FIRST   = 7'h30;  // '0'
    localparam logic [6:0] DG_LAST    = 7'h39;  // '9'
    localparam logic [6:0] PLUS_CODE  = 7'h2B;  // '+'
    localparam logic [6:0] SLASH_CODE = 7'h2F;  // '/'
    localparam logic [6:0] PAD_CODE   = 7'h3D;  // '='

    localparam logic [SYM_W-1:0] LC_BASE    = 6'd26;
    localparam logic [SYM_W-1:0] DG_BASE    = 6'd52;
    localparam logic [SYM_W-1:0] PLUS_SYM   = 6'd62;
    localparam logic [SYM_W-1:0] SLASH_SYM  = 6'd63;

    // Worst case fill: CHAR_W-1 leftover bits plus one freshly accepted symbol.
    function automatic int acc_width(input int char_w);
        return char_w - 1 + SYM_W;
    endfunction

endpackage

// File: rtl/base64_serial_decoder_if.sv
// Stream interface of the base64 serial decoder: character handshake in,
// serial/parallel decoded characters and status out.
interface base64_serial_decoder_if #(
    parameter int CHAR_W = 7
);
    logic [6:0]        in_char;
    logic              in_valid;
    logic              in_ready;
    logic              over;
    logic              bit_out;
    logic              bit_valid;
    logic [CHAR_W-1:0] ascii;
    logic              ascii_on;
    logic [2:0]        bit_cnt;
    logic              done;
    logic              err;

    modport master (
        output in_char, in_valid, over,
        input  in_ready, bit_out, bit_valid, ascii, ascii_on, bit_cnt, done, err
    );

    modport slave (
        input  in_char, in_valid, over,
        output in_ready, bit_out, bit_valid, ascii, ascii_on, bit_cnt, done, err
    );
endinterface

// File: rtl/b64_sym_decode.sv
// Combinational base64 character classifier: ASCII code -> 6-bit symbol,
// with flags for a legal code (symbol or pad) and for the '=' pad.
module b64_sym_decode
    import b64_pkg::*;
(
    input  logic [6:0]       in_char,
    output logic [SYM_W-1:0] sym,
    output logic             is_valid,
    output logic             is_pad
);
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        sym      = '0;
        is_valid = 1'b1;
        is_pad   = 1'b0;
        if (in_char inside {[UC_FIRST:UC_LAST]}) begin
            sym = SYM_W'(in_char - UC_FIRST);
        end else if (in_char inside {[LC_FIRST:LC_LAST]}) begin
            sym = SYM_W'(in_char - LC_FIRST) + LC_BASE;
        end else if (in_char inside {[DG_FIRST:DG_LAST]}) begin
            sym = SYM_W'(in_char - DG_FIRST) + DG_BASE;
        end else if (in_char == PLUS_CODE) begin
            sym = PLUS_SYM;
        end else if (in_char == SLASH_CODE) begin
            sym = SLASH_SYM;
        end else if (in_char == PAD_CODE) begin
            is_pad = 1'b1;
        end else begin
            is_valid = 1'b0;
        end
    end
endmodule

// File: rtl/base64_serial_decoder.sv
// Base64 characters in, CHAR_W-bit characters out (serial MSB-first plus parallel strobe).
// Define B64DEC_STRICT_EN to flag an invalid character on err (sticky) and block further input.
module base64_serial_decoder
    import b64_pkg::*;
#(
    parameter int CHAR_W = 7
) (
    input logic                   clk,
    input logic                   reset,
    base64_serial_decoder_if.slave bus
);
    localparam int                ACC_W    = acc_width(CHAR_W);
    localparam int                CNT_W    = $clog2(ACC_W + 1);
    localparam logic [CNT_W-1:0]  CHAR_CNT = CNT_W'(CHAR_W);
    localparam logic [CNT_W-1:0]  SYM_CNT  = CNT_W'(SYM_W);
    localparam logic [2:0]        TOP_BIT  = 3'(CHAR_W - 1);

    logic [SYM_W-1:0]  sym;
    logic              is_valid;
    logic              is_pad;

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  acc_cnt;
    logic [CHAR_W-1:0] shreg;
    logic              over_lat;
    logic              alive;
    logic              err_q;
    logic              bit_out_q;
    logic              bit_valid_q;
    logic              ascii_on_q;
    logic              done_q;
    logic [CHAR_W-1:0] ascii_q;
    logic [2:0]        bit_cnt_q;

    logic              avail;
    logic              take;
    logic              load;
    logic [CHAR_W-1:0] char_sel;

    b64_sym_decode u_sym_decode (
        .in_char  (bus.in_char),
        .sym      (sym),
        .is_valid (is_valid),
        .is_pad   (is_pad)
    );

    // alive keeps in_ready low while reset is asserted so every output reads 0.
    assign avail        = acc_cnt >= CHAR_CNT;
    assign bus.in_ready = alive && !avail && !done_q && !err_q;
    assign take         = bus.in_valid && bus.in_ready;
    assign load         = avail && (state == IDLE || (state == SHIFT && bit_cnt_q == '0));
    assign char_sel     = CHAR_W'(acc >> (acc_cnt - CHAR_CNT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            acc         <= '0;
            acc_cnt     <= '0;
            shreg       <= '0;
            over_lat    <= 1'b0;
            alive       <= 1'b0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            ascii_on_q  <= 1'b0;
            done_q      <= 1'b0;
            ascii_q     <= '0;
            bit_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            alive      <= 1'b1;
            over_lat   <= over_lat | bus.over;
            ascii_on_q <= 1'b0;
            // take needs !avail and load needs avail, so acc_cnt has one writer per edge.
            if (take && is_valid && !is_pad) begin
                acc     <= {acc[ACC_W-SYM_W-1:0], sym};
                acc_cnt <= acc_cnt + SYM_CNT;
            end
            if (load) begin
                acc_cnt     <= acc_cnt - CHAR_CNT;
                ascii_q     <= char_sel;
                ascii_on_q  <= 1'b1;
                bit_out_q   <= char_sel[CHAR_W-1];
                bit_valid_q <= 1'b1;
                bit_cnt_q   <= TOP_BIT;
                shreg       <= {char_sel[CHAR_W-2:0], 1'b0};
                state       <= SHIFT;
            end else begin
                case (state)
                    IDLE: begin
                        if (over_lat) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (bit_cnt_q == '0) begin
                            bit_valid_q <= 1'b0;
                            bit_out_q   <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q - 3'd1;
                            bit_out_q <= shreg[CHAR_W-1];
                            shreg     <= {shreg[CHAR_W-2:0], 1'b0};
                        end
                    end
                    DONE:    ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef B64DEC_STRICT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (take && !is_valid) begin
            err_q <= 1'b1;
        end
    end
`else
    assign err_q = 1'b0;
`endif

    assign bus.bit_out   = bit_out_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.ascii     = ascii_q;
    assign bus.ascii_on  = ascii_on_q;
    assign bus.bit_cnt   = bit_cnt_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_base64_serial_decoder.sv
// Self-checking bench for base64_serial_decoder: table vectors, hand-written corner
// sequences and random streams against a bit-queue reference model.
module tb_base64_serial_decoder;
    localparam int CHAR_W = 7;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    base64_serial_decoder_if #(.CHAR_W(CHAR_W)) bus ();

    base64_serial_decoder #(.CHAR_W(CHAR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- output monitor ----------------
    logic [7:0] got_chars[$];
    bit         got_bits[$];
    int         exp_cnt  = 0;
    int         cyc      = 0;
    int         first_bv = -1;
    int         last_bv  = -1;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            if (bus.ascii_on) begin
                check("strobe_bit_valid", bus.bit_valid, 1);
                check("strobe_bit_cnt", bus.bit_cnt, CHAR_W - 1);
                got_chars.push_back(8'(bus.ascii));
                exp_cnt = CHAR_W - 1;
            end
            if (bus.bit_valid) begin
                check("bit_cnt", bus.bit_cnt, exp_cnt);
                got_bits.push_back(bus.bit_out);
                exp_cnt--;
                if (first_bv < 0) first_bv = cyc;
                last_bv = cyc;
            end
        end
    end

    task automatic clear_mon();
        got_chars.delete();
        got_bits.delete();
        exp_cnt  = 0;
        first_bv = -1;
        last_bv  = -1;
    endtask

    // ---------------- reference model ----------------
    logic [7:0] exp_q[$];

    function automatic int b64_val(input byte c);
        string alpha = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789+/";
        for (int i = 0; i < 64; i++) if (alpha[i] == c) return i;
        return -1;
    endfunction

    task automatic model_build(input string s);
        bit q[$];
        int v;
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) begin
            v = b64_val(s[i]);
            if (v >= 0) for (int b = 5; b >= 0; b--) q.push_back(v[b]);
        end
        while (q.size() >= CHAR_W) begin
            logic [7:0] ch;
            ch = 8'd0;
            for (int k = 0; k < CHAR_W; k++) ch = {ch[6:0], q.pop_front()};
            exp_q.push_back(ch);
        end
    endtask

    task automatic exp_from_string(input string e);
        exp_q.delete();
        for (int i = 0; i < e.len(); i++) exp_q.push_back(e[i]);
    endtask

    task automatic compare_output(input string tag);
        int nbad = 0;
        int nb;
        check({tag, "_char_count"}, got_chars.size(), exp_q.size());
        for (int i = 0; i < got_chars.size() && i < exp_q.size(); i++)
            check({tag, "_char"}, got_chars[i], exp_q[i]);
        nb = exp_q.size() * CHAR_W;
        check({tag, "_bit_count"}, got_bits.size(), nb);
        for (int i = 0; i < got_bits.size() && i < nb; i++) begin
            logic [7:0] c;
            c = exp_q[i / CHAR_W];
            if (got_bits[i] !== c[CHAR_W - 1 - (i % CHAR_W)]) nbad++;
        end
        check({tag, "_bit_errors"}, nbad, 0);
    endtask

    // ---------------- drivers ----------------
    task automatic check_all_zero(input string tag);
        check(tag, {bus.in_ready, bus.bit_out, bus.bit_valid, bus.ascii, bus.ascii_on,
                    bus.bit_cnt, bus.done, bus.err}, 0);
    endtask

    task automatic apply_reset();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_char  = 7'd0;
        bus.over     = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset_outputs");
        clear_mon();
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; holds in_valid across consecutive characters.
    task automatic send(input string s, input bit over_last);
        for (int i = 0; i < s.len(); i++) begin
            int guard = 0;
            bus.in_char  = 7'(s[i]);
            bus.in_valid = 1'b1;
            while (!bus.in_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) begin
                check("in_ready_timeout", bus.in_ready, 1);
                break;
            end
            if (over_last && i == s.len() - 1) bus.over = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.over     = 1'b0;
    endtask

    task automatic pulse_over();
        bus.over = 1'b1;
        @(negedge clk);
        bus.over = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int g = 0;
        while (!bus.done && g < 500) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_done"}, bus.done, 1);
        repeat (2) @(negedge clk);
        check({tag, "_done_idle"}, {bus.in_ready, bus.bit_valid, bus.done}, 3'b001);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string stream;
        bit    over_last;
        string exp;
        bit    chk_gap;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input string s, input bit o, input string e, input bit g);
        vec_t v;
        v.stream    = s;
        v.over_last = o;
        v.exp       = e;
        v.chk_gap   = g;
        vq.push_back(v);
    endtask

    string alpha_s = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789+/";

    initial begin
        bus.in_valid = 1'b0;
        bus.in_char  = 7'd0;
        bus.over     = 1'b0;

        add_vec("gg",   1'b0, "A",   1'b0);
        add_vec("kaQ",  1'b0, "Hi",  1'b1);
        add_vec("kaQ",  1'b1, "Hi",  1'b1);
        add_vec("gg==", 1'b0, "A",   1'b0);
        add_vec("TWFu", 1'b0, "&X-", 1'b1);
        add_vec("",     1'b0, "",    1'b0);
`ifndef B64DEC_STRICT_EN
        add_vec("ka*Q", 1'b0, "Hi",  1'b1);
`endif

        foreach (vq[n]) begin
            apply_reset();
            send(vq[n].stream, vq[n].over_last);
            if (!vq[n].over_last) pulse_over();
            wait_done("table");
            exp_from_string(vq[n].exp);
            compare_output("table");
            if (vq[n].chk_gap)
                check("table_no_gap", last_bv - first_bv + 1, got_bits.size());
            check("table_err", bus.err, 0);
        end

        // Latency: the symbol completing a character strobes one edge later.
        apply_reset();
        send("g", 1'b0);
        bus.in_char  = 7'h67;
        bus.in_valid = 1'b1;
        check("latency_ready", bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        check("latency_not_yet", bus.ascii_on, 0);
        @(posedge clk);
        #1;
        check("latency_strobe", bus.ascii_on, 1);
        check("latency_ascii", bus.ascii, 7'h41);
        check("latency_first_bit", bus.bit_out, 1);
        @(negedge clk);
        pulse_over();
        wait_done("latency");
        exp_from_string("A");
        compare_output("latency");

        // over on an empty stream: done exactly one edge after over is latched.
        apply_reset();
        bus.over = 1'b1;
        @(posedge clk);
        #1 bus.over = 1'b0;
        check("empty_done_early", bus.done, 0);
        @(posedge clk);
        #1;
        check("empty_done", bus.done, 1);
        @(negedge clk);
        check("empty_no_chars", got_chars.size(), 0);

        // Invalid character mid-stream.
        apply_reset();
`ifdef B64DEC_STRICT_EN
        send("ka*", 1'b0);
        check("strict_err", bus.err, 1);
        check("strict_blocked", bus.in_ready, 0);
        pulse_over();
        wait_done("strict");
        check("strict_err_sticky", bus.err, 1);
        exp_from_string("H");
        compare_output("strict");
`else
        send("*gg", 1'b0);
        pulse_over();
        wait_done("lenient");
        check("lenient_err", bus.err, 0);
        exp_from_string("A");
        compare_output("lenient");
`endif

        // Reset while shifting bit 3, then a clean restart.
        apply_reset();
        send("gg", 1'b0);
        begin
            int g = 0;
            while (!(bus.bit_valid && bus.bit_cnt == 3'd3) && g < 100) begin
                @(negedge clk);
                g++;
            end
            check("midreset_reach_bit3", {bus.bit_valid, bus.bit_cnt}, 4'b1011);
        end
        #2 reset = 1'b0;
        #1 check_all_zero("midreset_outputs");
        clear_mon();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send("gg", 1'b0);
        pulse_over();
        wait_done("restart");
        exp_from_string("A");
        compare_output("restart");

        // Random streams with in_valid held high, checked against the model.
        for (int r = 0; r < 10; r++) begin
            string s;
            int    len;
            s   = "";
            len = (r < 3) ? 16 : int'($urandom_range(4, 20));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 9) == 0) begin
                    s = {s, "="};
                end else begin
                    int k;
                    k = int'($urandom_range(0, 63));
                    s = {s, alpha_s.substr(k, k)};
                end
            end
            apply_reset();
            send(s, r[0]);
            if (!r[0]) pulse_over();
            wait_done("random");
            model_build(s);
            compare_output("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule
